wb_unit: RTL and testbench
==========================

Name: wb_unit

Overview:
- Writeback stage of the RV32I core; sole driver of the register file write port (RegW/Rd/Wd).
- Accepts completed MEM-stage results over a valid/ready handshake and waits for data-memory responses on loads, with a timeout.
- Aligns and extends load data, then issues one registered write per retired instruction.
- Also drives a bypass/forwarding copy of the write and a retired-instruction counter.

Parameters:
- TIMEOUT, 16, max cycles spent in WAIT_MEM before load abort (>=1).
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  MEM-stage result valid.
- in_ready  out  1  unit can accept; combinational from state.
- in_regw  in  1  instruction writes rd.
- in_rd  in  5  destination register.
- in_wbsel  in  2  00 ALU, 01 LOAD, 10 PC+4, 11 reserved (treated as ALU).
- in_alu  in  32  ALU result.
- in_pc4  in  32  PC+4.
- in_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- in_addr_lo  in  2  load address bits [1:0].
- dmem_rvalid  in  1  load data valid, single-cycle pulse.
- dmem_rdata  in  32  raw aligned word from data memory.
- dmem_err  in  1  bus error, qualified by dmem_rvalid.
- RegW  out  1  register file write enable.
- Rd  out  5  register file write address.
- Wd  out  32  register file write data.
- fwd_valid  out  1  same cycle and value as RegW, for the EX bypass.
- fwd_rd  out  5  equals Rd.
- fwd_data  out  32  equals Wd.
- load_err  out  1  one-cycle pulse on misaligned, illegal, bus-error or timed-out load.
- busy  out  1  high in WAIT_MEM.
- retired  out  CNT_W  count of instructions completed without error.

Behaviour:
- Reset (async, rst_n=0): state IDLE. RegW, Rd, Wd, fwd_*, load_err, busy and retired all 0. Timeout counter 0. Release is synchronous to the next clk edge.
- States: IDLE, WAIT_MEM, WRITE.
- in_ready=1 in IDLE and WRITE; 0 in WAIT_MEM. An instruction is accepted on a clk edge where in_valid & in_ready.
- Non-load accept: next state WRITE.
  - In the following cycle: RegW = in_regw & (in_rd!=0), Rd = in_rd, Wd = in_alu or in_pc4; retired increments.
  - Latency is 1 cycle from accept to RegW.
- Load accept, alignment checks:
  - Misaligned: LW with addr_lo!=0, or LH/LHU with addr_lo[0]=1.
  - Illegal: funct3 not in the legal set.
  - Either case: no memory wait, load_err=1 next cycle, RegW=0, next state IDLE, retired unchanged.
- Load accept, otherwise: latch rd, regw, funct3 and addr_lo; go to WAIT_MEM; timeout counter cleared; busy=1.
- In WAIT_MEM:
  - Counter increments each cycle.
  - dmem_rvalid & !dmem_err: extract, go to WRITE, write next cycle (rvalid to RegW = 1 cycle); retired increments.
  - dmem_rvalid & dmem_err: load_err pulse, RegW=0, go to IDLE.
  - No rvalid when counter reaches TIMEOUT-1: load_err pulse, go to IDLE. A later stray rvalid is ignored.
- Extraction:
  - LB/LBU use byte addr_lo (bits [8*addr_lo+7 : 8*addr_lo]).
  - LH/LHU use halfword addr_lo[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- In WRITE:
  - RegW/Wd valid for exactly one cycle.
  - A same-cycle accept of a new instruction is legal (back-to-back non-loads give RegW every cycle).
  - With no accept, next state IDLE and RegW returns to 0.
- Rd==0: RegW and fwd_valid forced 0, but the instruction still retires. Rd and Wd still show their values.
- In IDLE, Rd and Wd hold their last values; RegW is 0.
- dmem_rvalid outside WAIT_MEM is ignored.
- retired wraps modulo 2^CNT_W.
- Reset asserted in WAIT_MEM or WRITE: any pending write is dropped, with no RegW pulse.

Test Plan:
- ALU to x5=0x1234_5678, then PC+4 to x6=0x0000_0104 on back-to-back cycles -> RegW high two consecutive cycles; Rd 5 then 6; Wd as given; retired=2.
- LB addr_lo=3, rdata=0x80FF_FFFF, rvalid 4 cycles later -> busy for 4 cycles; Wd=0xFFFF_FF80 one cycle after rvalid; LBU same stimulus -> Wd=0x0000_0080.
- LH addr_lo=2, rdata=0x8001_0000 -> Wd=0xFFFF_8001. LW addr_lo=1 -> load_err next cycle, no RegW, in_ready stays 1.
- TIMEOUT=16, load with no rvalid -> load_err on the 16th WAIT_MEM cycle, return to IDLE, no RegW; rvalid injected afterwards is ignored.
- ALU write to x0 with in_regw=1 -> RegW=0, retired increments. rvalid with dmem_err=1 -> load_err, no write.
- rst_n low while in WAIT_MEM, then rvalid after release -> no RegW, all outputs 0, state IDLE.

Source files
------------

// File: rtl/wb_unit_if.sv
// Writeback-stage bus: the MEM-stage result handshake, the data-memory response,
// and the register-file write port with its bypass copy.
interface wb_unit_if;
  // Handshake: a result transfers on the rising clk edge where in_valid and in_ready
  // are both high; in_valid may change freely while in_ready is low.
  logic        in_valid;
  logic        in_ready;
  logic        in_regw;
  logic [4:0]  in_rd;
  logic [1:0]  in_wbsel;
  logic [31:0] in_alu;
  logic [31:0] in_pc4;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        dmem_err;
  logic        RegW;
  logic [4:0]  Rd;
  logic [31:0] Wd;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;

  modport master (
    output in_valid, in_regw, in_rd, in_wbsel, in_alu, in_pc4, in_funct3, in_addr_lo,
    output dmem_rvalid, dmem_rdata, dmem_err,
    input  in_ready, RegW, Rd, Wd, fwd_valid, fwd_rd, fwd_data
  );

  modport slave (
    input  in_valid, in_regw, in_rd, in_wbsel, in_alu, in_pc4, in_funct3, in_addr_lo,
    input  dmem_rvalid, dmem_rdata, dmem_err,
    output in_ready, RegW, Rd, Wd, fwd_valid, fwd_rd, fwd_data
  );
endinterface

// File: rtl/wb_unit.sv
// RV32I writeback stage: retires MEM-stage results, waits on load data with a
// timeout, aligns/extends loads and issues one registered register-file write.
module wb_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  wb_unit_if.slave         bus,
  output logic             load_err,
  output logic             busy,
  output logic [CNT_W-1:0] retired,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_MEM = 2'd1,
    S_WRITE    = 2'd2
  } state_t;

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t        state;
  logic [TW-1:0] tmo_cnt;
  logic [4:0]    l_rd;
  logic          l_regw;
  logic [2:0]    l_funct3;
  logic [1:0]    l_addr_lo;

  logic        accept;
  logic        is_load;
  logic        load_bad;
  logic [31:0] nonload_wd;

  function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] lo,
                                          input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {lo, 3'b000});
    h = lo[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  extract = {{24{b[7]}}, b};
      3'b100:  extract = {24'd0, b};
      3'b001:  extract = {{16{h[15]}}, h};
      3'b101:  extract = {16'd0, h};
      default: extract = w;
    endcase
  endfunction

  assign bus.in_ready  = (state != S_WAIT_MEM);
  assign accept        = bus.in_valid & bus.in_ready;
  assign is_load       = (bus.in_wbsel == 2'b01);
  assign nonload_wd    = (bus.in_wbsel == 2'b10) ? bus.in_pc4 : bus.in_alu;
  assign bus.fwd_valid = bus.RegW;
  assign bus.fwd_rd    = bus.Rd;
  assign bus.fwd_data  = bus.Wd;
  assign state_dbg     = state;

  // Misaligned or illegal-funct3 loads abort at accept without touching memory.
  always_comb begin
    load_bad = 1'b0;
    case (bus.in_funct3)
      3'b000, 3'b100: load_bad = 1'b0;
      3'b001, 3'b101: load_bad = bus.in_addr_lo[0];
      3'b010:         load_bad = |bus.in_addr_lo;
      default:        load_bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      tmo_cnt   <= '0;
      l_rd      <= '0;
      l_regw    <= 1'b0;
      l_funct3  <= '0;
      l_addr_lo <= '0;
      bus.RegW  <= 1'b0;
      bus.Rd    <= '0;
      bus.Wd    <= '0;
      load_err  <= 1'b0;
      busy      <= 1'b0;
      retired   <= '0;
    end else begin
      bus.RegW <= 1'b0;
      load_err <= 1'b0;
      case (state)
        S_IDLE, S_WRITE: begin
          if (accept) begin
            if (is_load) begin
              if (load_bad) begin
                load_err <= 1'b1;
                state    <= S_IDLE;
              end else begin
                l_rd      <= bus.in_rd;
                l_regw    <= bus.in_regw;
                l_funct3  <= bus.in_funct3;
                l_addr_lo <= bus.in_addr_lo;
                tmo_cnt   <= '0;
                busy      <= 1'b1;
                state     <= S_WAIT_MEM;
              end
            end else begin
              bus.RegW <= bus.in_regw & (bus.in_rd != 5'd0);
              bus.Rd   <= bus.in_rd;
              bus.Wd   <= nonload_wd;
              retired  <= retired + CNT_W'(1);
              state    <= S_WRITE;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_WAIT_MEM: begin
          // A response arriving in the last allowed cycle still wins over the timeout.
          if (bus.dmem_rvalid) begin
            busy <= 1'b0;
            if (bus.dmem_err) begin
              load_err <= 1'b1;
              state    <= S_IDLE;
            end else begin
              bus.RegW <= l_regw & (l_rd != 5'd0);
              bus.Rd   <= l_rd;
              bus.Wd   <= extract(l_funct3, l_addr_lo, bus.dmem_rdata);
              retired  <= retired + CNT_W'(1);
              state    <= S_WRITE;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            busy     <= 1'b0;
            load_err <= 1'b1;
            state    <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_unit.sv
// Self-checking bench for wb_unit: directed cases plus a randomised mix, with a
// scoreboard queue of expected register-file writes.
module tb_wb_unit;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 32;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_unit_if bus ();
  logic             load_err;
  logic             busy;
  logic [CNT_W-1:0] retired;
  logic [1:0]       state_dbg;

  wb_unit #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .load_err  (load_err),
    .busy      (busy),
    .retired   (retired),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int          n_vec  = 0;
  int          n_miss = 0;
  logic [36:0] exp_q[$];
  logic [31:0] exp_ret = '0;
  int          busy_cyc = 0;
  int          err_cnt  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [36:0] e;
    if (busy) busy_cyc++;
    if (load_err) err_cnt++;
    if (bus.RegW || bus.fwd_valid) begin
      if (exp_q.size() == 0) begin
        check("unexp_write", 64'(bus.RegW | bus.fwd_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_port", {bus.fwd_valid, bus.RegW, bus.Rd, bus.Wd}, {2'b11, e});
        check("fwd_port", {bus.fwd_rd, bus.fwd_data}, e);
      end
    end
  end

  // ---------------- model ----------------
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] lo,
                                             input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = (lo >= 2'd2) ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'd0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid    = 1'b0;
    bus.in_regw     = 1'b0;
    bus.in_rd       = '0;
    bus.in_wbsel    = '0;
    bus.in_alu      = '0;
    bus.in_pc4      = '0;
    bus.in_funct3   = '0;
    bus.in_addr_lo  = '0;
    bus.dmem_rvalid = 1'b0;
    bus.dmem_rdata  = '0;
    bus.dmem_err    = 1'b0;
  endtask

  // Presents one instruction and returns 1ns after the accepting edge.
  task automatic send(input logic regw, input logic [4:0] rd, input logic [1:0] wbsel,
                      input logic [31:0] alu, input logic [31:0] pc4,
                      input logic [2:0] f3, input logic [1:0] lo);
    int guard = 0;
    bus.in_valid   = 1'b1;
    bus.in_regw    = regw;
    bus.in_rd      = rd;
    bus.in_wbsel   = wbsel;
    bus.in_alu     = alu;
    bus.in_pc4     = pc4;
    bus.in_funct3  = f3;
    bus.in_addr_lo = lo;
    while (!bus.in_ready && guard < 50) begin
      tick(1);
      guard++;
    end
    if (guard >= 50) check("ready_timeout", 64'(bus.in_ready), 64'd1);
    tick(1);
    bus.in_valid = 1'b0;
    if (wbsel != 2'b01) begin
      exp_ret++;
      if (regw && rd != 5'd0) exp_q.push_back({rd, (wbsel == 2'b10) ? pc4 : alu});
    end
  endtask

  task automatic mem_pulse(input int delay, input logic [31:0] data, input logic err);
    if (delay > 0) tick(delay);
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = data;
    bus.dmem_err    = err;
    tick(1);
    bus.dmem_rvalid = 1'b0;
    bus.dmem_err    = 1'b0;
    bus.dmem_rdata  = $urandom;
  endtask

  task automatic good_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo,
                           input int delay, input logic [31:0] data);
    send(1'b1, rd, 2'b01, 32'd0, 32'd0, f3, lo);
    mem_pulse(delay, data, 1'b0);
    exp_ret++;
    if (rd != 5'd0) exp_q.push_back({rd, model_load(f3, lo, data)});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int b0, e0;
    logic [2:0] f3_tab[5];
    f3_tab[0] = 3'b000; f3_tab[1] = 3'b001; f3_tab[2] = 3'b010;
    f3_tab[3] = 3'b100; f3_tab[4] = 3'b101;
    idle_inputs();
    #12;
    check("rst_outs", {bus.RegW, bus.Rd, bus.Wd, bus.fwd_valid, load_err, busy},
          {1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0});
    check("rst_cnt", {retired, 30'd0, state_dbg}, 64'd0);
    check("rst_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(1);

    // back-to-back ALU then PC+4
    send(1'b1, 5'd5, 2'b00, 32'h1234_5678, 32'h0000_0000, 3'b010, 2'd0);
    check("b2b_first", {bus.RegW, bus.Rd}, {1'b1, 5'd5});
    send(1'b1, 5'd6, 2'b10, 32'hDEAD_BEEF, 32'h0000_0104, 3'b010, 2'd0);
    check("b2b_second", {bus.RegW, bus.Rd, bus.Wd}, {1'b1, 5'd6, 32'h0000_0104});
    tick(2);
    check("b2b_retired", retired, 64'd2);
    check("idle_regw", 64'(bus.RegW), 64'd0);

    // LB / LBU with a 4-cycle memory wait
    b0 = busy_cyc;
    good_load(5'd7, 3'b000, 2'd3, 3, 32'h80FF_FFFF);
    check("lb_busy_cycles", 64'(busy_cyc - b0), 64'd4);
    tick(2);
    good_load(5'd8, 3'b100, 2'd3, 3, 32'h80FF_FFFF);
    tick(2);
    good_load(5'd9, 3'b001, 2'd2, 1, 32'h8001_0000);
    tick(2);

    // misaligned / illegal loads
    send(1'b1, 5'd10, 2'b01, 32'd0, 32'd0, 3'b010, 2'd1);
    check("lw_misalign", {bus.RegW, load_err, bus.in_ready, busy}, {1'b0, 1'b1, 1'b1, 1'b0});
    tick(1);
    check("err_one_cycle", 64'(load_err), 64'd0);
    send(1'b1, 5'd10, 2'b01, 32'd0, 32'd0, 3'b101, 2'd1);
    check("lhu_misalign", {bus.RegW, load_err}, {1'b0, 1'b1});
    send(1'b1, 5'd10, 2'b01, 32'd0, 32'd0, 3'b011, 2'd0);
    check("illegal_f3", {bus.RegW, load_err, 30'd0, state_dbg}, {1'b0, 1'b1, 32'd0});
    tick(2);

    // timeout
    b0 = busy_cyc; e0 = err_cnt;
    send(1'b1, 5'd11, 2'b01, 32'd0, 32'd0, 3'b010, 2'd0);
    tick(15);
    check("tmo_before", {load_err, busy, bus.in_ready}, {1'b0, 1'b1, 1'b0});
    tick(1);
    check("tmo_pulse", {load_err, busy, bus.RegW, 30'd0, state_dbg}, {1'b1, 1'b0, 1'b0, 32'd0});
    tick(2);
    check("tmo_busy_cycles", 64'(busy_cyc - b0), 64'd16);
    mem_pulse(1, 32'hCAFE_F00D, 1'b0);
    tick(2);
    check("tmo_err_count", 64'(err_cnt - e0), 64'd1);

    // response in the last allowed wait cycle
    good_load(5'd12, 3'b010, 2'd0, TIMEOUT - 1, 32'hA5A5_0F0F);
    tick(2);

    // write to x0 still retires
    send(1'b1, 5'd0, 2'b00, 32'h5555_AAAA, 32'd0, 3'b000, 2'd0);
    check("x0_no_write", {bus.RegW, bus.fwd_valid, bus.Wd}, {1'b0, 1'b0, 32'h5555_AAAA});
    tick(1);
    check("x0_retired", retired, 64'(exp_ret));

    // bus error response
    send(1'b1, 5'd13, 2'b01, 32'd0, 32'd0, 3'b010, 2'd0);
    mem_pulse(2, 32'h1111_2222, 1'b1);
    check("bus_err", {bus.RegW, load_err, busy, 30'd0, state_dbg}, {1'b0, 1'b1, 1'b0, 32'd0});
    tick(2);

    // random mix; zero gaps exercise back-to-back accepts
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        int k;
        logic [1:0] lo;
        k  = $urandom_range(0, 4);
        lo = 2'($urandom_range(0, 3));
        if (f3_tab[k] == 3'b010) lo = 2'd0;
        else if (f3_tab[k][0]) lo[0] = 1'b0;
        good_load(5'($urandom_range(0, 31)), f3_tab[k], lo, $urandom_range(0, TIMEOUT - 1), $urandom);
      end else begin
        send(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
             $urandom, $urandom, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
      end
      if ($urandom_range(0, 1) == 1) tick($urandom_range(1, 2));
    end
    tick(3);
    check("rand_retired", retired, 64'(exp_ret));

    // reset while waiting for memory drops the pending write
    send(1'b1, 5'd14, 2'b01, 32'd0, 32'd0, 3'b010, 2'd0);
    tick(2);
    rst_n = 1'b0;
    exp_ret = '0;
    #2;
    check("rst_wait_outs", {bus.RegW, bus.Rd, bus.Wd, load_err, busy},
          {1'b0, 5'd0, 32'd0, 1'b0, 1'b0});
    check("rst_wait_cnt", {retired, 30'd0, state_dbg}, 64'd0);
    tick(1);
    rst_n = 1'b1;
    mem_pulse(1, 32'h7777_8888, 1'b0);
    tick(2);
    check("post_rst", {bus.RegW, bus.Rd, bus.Wd, load_err, busy, 30'd0, state_dbg},
          {1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0});
    check("post_rst_ret", retired, 64'(exp_ret));
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end

endmodule
